mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Sequential shift-add multiplier controller for the COA datapath. It latches a multiplicand into an internal X register and a multiplier into a shifting Y register. It then sequences WIDTH add/shift iterations into an accumulator and returns an unsigned 2·WIDTH-bit product under a start/busy/done handshake. It sits beside the register file and ALU, sharing the x_reg-style operand registers, and gives the CPU a fixed-latency multiply unit.

## Interface
- WIDTH, 32, operand width in bits; product is 2·WIDTH bits; legal range 4..64
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
- start  in  1  request; accepted only in IDLE
- multiplicand  in  WIDTH  operand A, sampled on the accepting edge only
- multiplier  in  WIDTH  operand B, sampled on the accepting edge only
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse, product valid
- product  out  2·WIDTH  result register; holds its value until the next accepted start or reset

## Operation
- Internal registers: X (WIDTH, multiplicand), Y (WIDTH, multiplier, shifts right), ACC (WIDTH+1, upper partial product incl. carry), cnt (clog2(WIDTH)+1 bits).
- States: IDLE, CALC, DONE. Registered state encoding; all outputs registered.
- IDLE: if start=1, then X<=multiplicand, Y<=multiplier, ACC<=0, cnt<=0, busy<=1, and the next state is CALC. Otherwise stay in IDLE.
- CALC, each edge:
  - sum = ACC[WIDTH-1:0] + (Y[0] ? X : 0), computed WIDTH+1 bits wide.
  - {ACC, Y} <= {sum, Y} >> 1, a logical right shift of the 2·WIDTH+1-bit concatenation.
  - cnt <= cnt+1.
- CALC exit: on the edge where cnt = WIDTH-1, the final iteration is performed and the results are written:
  - product <= {sum, Y} >> 1, truncated to 2·WIDTH bits;
  - busy <= 0, done <= 1, next state DONE.
- DONE: done <= 0 and the next state is IDLE. start is ignored in DONE.
- start while busy or in DONE: ignored, with no effect on operands or state.
- Arithmetic is unsigned only. Intermediate sums never exceed WIDTH+1 bits, so the product is exact with no overflow.
- Reset (rst=0 at an edge), from any state including mid-CALC:
  - state <= IDLE, busy <= 0, done <= 0, product <= 0, X/Y/ACC/cnt <= 0.
  - The in-flight operation is discarded and no done pulse is emitted.

## Timing
- Reset values: busy=0, done=0, product=0.
- Accept edge E0 (IDLE, start=1): busy is high from E0.
- Iterations occur on edges E1..E_WIDTH. product is updated and done rises at E_WIDTH; done falls at E_WIDTH+1.
- Latency from the accept edge to done: WIDTH cycles (32 for the default). The next start is accepted no earlier than E_WIDTH+2, giving a throughput of one multiply per WIDTH+2 cycles.
- A start held high continuously causes back-to-back operations at the WIDTH+2 cadence. Operands are re-sampled on each accept edge.
- Operand inputs may change freely after E0 without affecting the result.
- Simultaneous rst=0 and start=1: reset wins and the start is not accepted.

## Test plan
- Basic: after reset, start with multiplicand=3, multiplier=5 -> busy high for 32 cycles; done pulses once, exactly 32 edges after accept; product=0x000000000000000F.
- Max operands: 0xFFFFFFFF × 0xFFFFFFFF -> product=0xFFFFFFFE00000001, exercising the carry into bit WIDTH of ACC.
- Zero / pattern: 0xDEADBEEF × 0 -> product=0. Then 0xDEADBEEF × 0x00000002 -> product=0x00000001BD5B7DDE.
- Ignored start: accept 7×9, then pulse start with 100×100 at cycle 10 of CALC -> product=63 (0x3F); only one done pulse; the second request is not queued.
- Reset mid-op: accept 0x12345678×0x10, drive rst=0 at cycle 16 -> next edge busy=0, done=0, product=0. No done appears afterwards, and a subsequent 2×2 request yields 4.
- Back-to-back: hold start=1 with operands changing each op (1×1, 2×3) -> done pulses 34 cycles apart, with products 1 then 6.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if
//   Start/busy/done handshake and operand/result bus for the sequential
//   shift-add multiplier.
//   master : requester (CPU side) drives start and both operands
//   slave  : multiplier controller drives busy, done and product
//   start        request, accepted only while the multiplier is idle
//   multiplicand operand A (WIDTH bits)
//   multiplier   operand B (WIDTH bits)
//   busy         high while iterations are in progress
//   done         one-cycle pulse, product valid
//   product      2*WIDTH-bit unsigned result, held until next accept/reset
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Sequential shift-add multiplier controller. Latches the multiplicand into
//   X and the multiplier into a right-shifting Y register, then performs WIDTH
//   add/shift iterations into ACC and returns the unsigned 2*WIDTH-bit product.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-low reset
//     bus  mul_seq_ctrl_if slave modport (start/operands in, busy/done/product out)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; operands sampled on the accepting edge
//   CALC  | one add/shift iteration per edge, WIDTH iterations in total
//   DONE  | product valid, done pulses for this single cycle
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mul_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic [WIDTH:0]       acc;
  logic [CW-1:0]        cnt;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     shifted;

  // ACC[WIDTH] is always zero after a shift (the logical shift feeds a 0 into
  // the top), so adding the full ACC equals adding ACC[WIDTH-1:0].
  always_comb begin
    sum     = acc + (y[0] ? {1'b0, x} : '0);
    shifted = {sum, y} >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            x      <= bus.multiplicand;
            y      <= bus.multiplier;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= shifted[2*WIDTH:WIDTH];
          y   <= shifted[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            product_q <= shifted[2*WIDTH-1:0];
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl
//   Self-checking bench for mul_seq_ctrl. Expected products come from plain
//   64-bit multiplication; timing expectations from the accept-edge schedule.
module tb_mul_seq_ctrl;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mul_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'b0, a};
    wb = {32'b0, b};
    return wa * wb;
  endfunction

  // One multiply: accept, run to done, check latency/busy/product.
  // poke > 0 re-asserts start with 100x100 at that CALC edge (must be ignored).
  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int poke);
    logic [63:0] expv;
    int lat;
    expv = ref_mul(a, b);
    lat  = -1;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk); #1;
    check({tag, "_busy_e0"}, {63'b0, bus.busy}, 64'd1);
    for (int c = 1; c <= WIDTH + 4; c++) begin
      @(negedge clk);
      bus.start        = (c == poke);
      bus.multiplicand = (c == poke) ? 32'd100 : $urandom;
      bus.multiplier   = (c == poke) ? 32'd100 : $urandom;
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c;
        break;
      end
      if (!bus.busy) begin
        check({tag, "_busy_calc"}, {63'b0, bus.busy}, 64'd1);
        break;
      end
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(WIDTH));
    check({tag, "_product"}, bus.product, expv);
    check({tag, "_busy_at_done"}, {63'b0, bus.busy}, 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check({tag, "_done_fall"}, {63'b0, bus.done}, 64'd0);
    end
    check({tag, "_product_hold"}, bus.product, expv);
  endtask

  initial begin
    int dones;
    int d1;
    int d2;
    logic [63:0] p1;
    logic [63:0] p2;
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_product", bus.product, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    mul_op("basic", 32'd3, 32'd5, 0);
    mul_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    mul_op("zero", 32'hDEAD_BEEF, 32'd0, 0);
    mul_op("pattern", 32'hDEAD_BEEF, 32'd2, 0);
    check("pattern_const", bus.product, 64'h0000_0001_BD5B_7DDE);

    mul_op("ignored", 32'd7, 32'd9, 10);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    check("ignored_not_queued", 64'(dones), 64'd0);
    check("ignored_product", bus.product, 64'h3F);

    // reset in the middle of CALC
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 32'h1234_5678;
    bus.multiplier   = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {63'b0, bus.busy}, 64'd0);
    check("midrst_done", {63'b0, bus.done}, 64'd0);
    check("midrst_product", bus.product, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    mul_op("after_rst", 32'd2, 32'd2, 0);

    // reset and start together: reset wins
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    check("rst_start_busy", {63'b0, bus.busy}, 64'd0);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("rst_start_idle", {63'b0, bus.busy}, 64'd0);

    // back-to-back with start held high
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 32'd1;
    bus.multiplier   = 32'd1;
    @(posedge clk);
    @(negedge clk);
    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd3;
    d1 = -1;
    d2 = -1;
    p1 = '0;
    p2 = '0;
    for (int t = 1; t <= 80; t++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = t;
          p1 = bus.product;
        end else begin
          d2 = t;
          p2 = bus.product;
          break;
        end
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_first_latency", 64'(d1), 64'(WIDTH));
    check("b2b_spacing", 64'(d2 - d1), 64'(WIDTH + 2));
    check("b2b_product1", p1, ref_mul(32'd1, 32'd1));
    check("b2b_product2", p2, ref_mul(32'd2, 32'd3));
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle", {63'b0, bus.busy}, 64'd0);

    // randomized operands
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'hFFFF_FFFF;
      if (i == 1) rb = 32'h8000_0000;
      mul_op("rand", ra, rb, (i % 3 == 0) ? int'($urandom_range(1, WIDTH - 1)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
